// File: rtl/lookup_result_merger_pkg.sv
// Shared definitions for the lookup result merger: FSM encoding, IOQ header
// destination-port field position and the default IOQ module-header ctrl value.
package lookup_result_merger_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam int         IOQ_DST_POS      = 48;
  localparam logic [7:0] IOQ_CTRL_DEFAULT = 8'hFF;

endpackage

// File: rtl/seconds_timer.sv
// Free-running seconds counter: divides the clock by 1e9/CLK_PERIOD_NS and
// counts elapsed seconds since reset, wrapping at 2^32.
module seconds_timer #(
  parameter int CLK_PERIOD_NS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] s_counter
);

  localparam int          TICKS_PER_SEC = 1_000_000_000 / CLK_PERIOD_NS;
  localparam logic [31:0] NS_TERMINAL   = 32'(TICKS_PER_SEC - 1);

  logic [31:0] ns_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ns_cnt    <= '0;
      s_counter <= '0;
    end else if (ns_cnt == NS_TERMINAL) begin
      ns_cnt    <= '0;
      s_counter <= s_counter + 32'd1;
    end else begin
      ns_cnt <= ns_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/lookup_result_merger.sv
// Merges packet words with their lookup result: stamps destination ports into the
// IOQ header, forwards or drops the packet. Optional stats: LOOKUP_MERGER_STATS_EN.
module lookup_result_merger
  import lookup_result_merger_pkg::*;
#(
  parameter int                    DATA_WIDTH        = 64,
  parameter int                    CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int                    NUM_OUTPUT_QUEUES = 8,
  parameter int                    CNT_WIDTH         = 32,
  parameter int                    CLK_PERIOD_NS     = 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL          = CTRL_WIDTH'(IOQ_CTRL_DEFAULT)
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [DATA_WIDTH-1:0]                  in_fifo_data,
  input  logic [CTRL_WIDTH-1:0]                  in_fifo_ctrl,
  input  logic                                   in_fifo_empty,
  output logic                                   in_fifo_rd_en,
  input  logic                                   result_fifo_empty,
  input  logic [NUM_OUTPUT_QUEUES-1:0]           result_dst_ports,
  input  logic                                   result_drop,
  output logic                                   result_fifo_rd_en,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic [CTRL_WIDTH-1:0]                  out_ctrl,
  output logic                                   out_wr,
  input  logic                                   out_rdy,
  output logic [NUM_OUTPUT_QUEUES*CNT_WIDTH-1:0] fwd_count,
  output logic [CNT_WIDTH-1:0]                   drop_count,
  output logic [31:0]                            s_counter
);

  state_t                state;
  logic                  drop_payload;
  logic                  xfer;
  logic                  in_payload;
  logic                  is_eop;
  logic [DATA_WIDTH-1:0] hdr_data;

  // Dropped packets are popped even while downstream is stalled.
  assign xfer = (state != IDLE) && !in_fifo_empty && (out_rdy || (state == DROP));
  assign in_payload = (state == PAYLOAD) || ((state == DROP) && drop_payload);
  assign is_eop = xfer && in_payload && (in_fifo_ctrl != '0);

  assign in_fifo_rd_en     = xfer;
  assign result_fifo_rd_en = is_eop;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    hdr_data = in_fifo_data;
    if ((state == HDR) && (in_fifo_ctrl == IOQ_CTRL))
      hdr_data[IOQ_DST_POS +: NUM_OUTPUT_QUEUES] = result_dst_ports;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      drop_payload <= 1'b0;
      out_data     <= '0;
      out_ctrl     <= '0;
      out_wr       <= 1'b0;
    end else begin
      out_wr <= xfer && (state != DROP);
      if (xfer && (state != DROP)) begin
        out_data <= hdr_data;
        out_ctrl <= in_fifo_ctrl;
      end

      case (state)
        IDLE: begin
          if (!in_fifo_empty && !result_fifo_empty) begin
            drop_payload <= 1'b0;
            state        <= result_drop ? DROP : HDR;
          end
        end
        HDR: begin
          if (xfer && (in_fifo_ctrl == '0)) state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (is_eop) state <= IDLE;
        end
        DROP: begin
          if (is_eop) state <= IDLE;
          else if (xfer && !drop_payload && (in_fifo_ctrl == '0)) drop_payload <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOOKUP_MERGER_STATS_EN
  logic [CNT_WIDTH-1:0] fwd_cnt [NUM_OUTPUT_QUEUES];
  logic [CNT_WIDTH-1:0] drop_cnt;
  logic                 fwd_eop;
  logic                 drop_eop;

  assign fwd_eop  = is_eop && (state == PAYLOAD);
  assign drop_eop = is_eop && (state == DROP);

  // NOTE: the counter array is a bank of flops, not a RAM, so it is reset
  // explicitly element by element.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) fwd_cnt[i] <= '0;
      drop_cnt <= '0;
    end else begin
      if (fwd_eop) begin
        for (int i = 0; i < NUM_OUTPUT_QUEUES; i++)
          if (result_dst_ports[i]) fwd_cnt[i] <= fwd_cnt[i] + CNT_WIDTH'(1);
      end
      if (drop_eop) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < NUM_OUTPUT_QUEUES; g++) begin : g_fwd
    assign fwd_count[g*CNT_WIDTH +: CNT_WIDTH] = fwd_cnt[g];
  end
  assign drop_count = drop_cnt;
`else
  assign fwd_count  = '0;
  assign drop_count = '0;
`endif

  seconds_timer #(
    .CLK_PERIOD_NS (CLK_PERIOD_NS)
  ) u_seconds_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_counter (s_counter)
  );

endmodule

// File: tb/tb_lookup_result_merger.sv
// Directed bench for lookup_result_merger: FIFO models on both inputs, an output
// capture queue and hand-computed expectations for each scenario.
module tb_lookup_result_merger;

  localparam int DW  = 64;
  localparam int CW  = 8;
  localparam int NQ  = 8;
  localparam int CNW = 32;
`ifdef LOOKUP_MERGER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DW-1:0]     in_fifo_data;
  logic [CW-1:0]     in_fifo_ctrl;
  logic              in_fifo_empty;
  logic              in_fifo_rd_en;
  logic              result_fifo_empty;
  logic [NQ-1:0]     result_dst_ports;
  logic              result_drop;
  logic              result_fifo_rd_en;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ctrl;
  logic              out_wr;
  logic              out_rdy;
  logic [NQ*CNW-1:0] fwd_count;
  logic [CNW-1:0]    drop_count;
  logic [31:0]       s_counter;

  always #5 clk = ~clk;

  lookup_result_merger #(
    .DATA_WIDTH (DW), .CTRL_WIDTH (CW), .NUM_OUTPUT_QUEUES (NQ), .CNT_WIDTH (CNW),
    .CLK_PERIOD_NS (250_000_000), .IOQ_CTRL (8'hFF)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .in_fifo_data (in_fifo_data), .in_fifo_ctrl (in_fifo_ctrl),
    .in_fifo_empty (in_fifo_empty), .in_fifo_rd_en (in_fifo_rd_en),
    .result_fifo_empty (result_fifo_empty), .result_dst_ports (result_dst_ports),
    .result_drop (result_drop), .result_fifo_rd_en (result_fifo_rd_en),
    .out_data (out_data), .out_ctrl (out_ctrl), .out_wr (out_wr), .out_rdy (out_rdy),
    .fwd_count (fwd_count), .drop_count (drop_count), .s_counter (s_counter)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int in_pops = 0;
  int res_pops = 0;
  logic take_in, take_res;

  logic [CW+DW-1:0] in_q[$];
  logic [NQ:0]      res_q[$];
  logic [DW-1:0]    out_d[$];
  logic [CW-1:0]    out_c[$];
  int               wr_cyc[$];
  int               pop_cyc[$];

  task automatic drive_heads();
    in_fifo_empty     = (in_q.size() == 0);
    in_fifo_data      = (in_q.size() != 0) ? in_q[0][DW-1:0] : '0;
    in_fifo_ctrl      = (in_q.size() != 0) ? in_q[0][CW+DW-1:DW] : '0;
    result_fifo_empty = (res_q.size() == 0);
    result_dst_ports  = (res_q.size() != 0) ? res_q[0][NQ:1] : '0;
    result_drop       = (res_q.size() != 0) ? res_q[0][0] : 1'b0;
  endtask

  // Pops take effect just after the edge on which the DUT asserted rd_en.
  always @(posedge clk) begin
    cyc++;
    take_in  = in_fifo_rd_en;
    take_res = result_fifo_rd_en;
    if (take_in) pop_cyc.push_back(cyc);
    #1;
    if (take_in && in_q.size() != 0) begin void'(in_q.pop_front()); in_pops++; end
    if (take_res && res_q.size() != 0) begin void'(res_q.pop_front()); res_pops++; end
    drive_heads();
  end

  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      out_d.push_back(out_data);
      out_c.push_back(out_ctrl);
      wr_cyc.push_back(cyc);
    end
  end

  function automatic logic [CNW-1:0] fwd(input int i);
    return fwd_count[i*CNW +: CNW];
  endfunction

  function automatic logic [DW-1:0] word_at(input int i);
    return (i < out_d.size()) ? out_d[i] : 'x;
  endfunction

  task automatic begin_test();
    out_d.delete(); out_c.delete(); wr_cyc.delete(); pop_cyc.delete();
  endtask

  task automatic push_word(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_q.push_back({c, d});
    drive_heads();
  endtask

  task automatic push_result(input logic [NQ-1:0] ports, input logic drop);
    res_q.push_back({ports, drop});
    drive_heads();
  endtask

  task automatic wait_res_pops(input int target);
    int n = 0;
    while (res_pops < target && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (res_pops < target) begin
      errors++;
      $display("FAIL result_pop_wait: got %0d pops, expected %0d", res_pops, target);
    end
    @(negedge clk);
  endtask

  task automatic wait_in_pops(input int target);
    int n = 0;
    while (in_pops < target && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (in_pops < target) begin
      errors++;
      $display("FAIL in_pop_wait: got %0d pops, expected %0d", in_pops, target);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL reset_out_wr: got %b expected 0", out_wr); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl: got %h expected 0", out_ctrl); end
    checks++; if (fwd_count !== '0 || drop_count !== '0) begin errors++; $display("FAIL reset_counters: got %h/%h expected 0", fwd_count, drop_count); end
    checks++; if (s_counter !== 32'd0) begin errors++; $display("FAIL reset_s_counter: got %h expected 0", s_counter); end
    checks++; if (in_fifo_rd_en !== 1'b0 || result_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b%b expected 00", in_fifo_rd_en, result_fifo_rd_en); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forward();
    logic [DW-1:0] exp_d [4] = '{64'h1104_2222_3333_4444, 64'hDEAD_BEEF_0000_0001,
                                 64'hDEAD_BEEF_0000_0002, 64'hCAFE_0000_0000_00FF};
    logic [CW-1:0] exp_c [4] = '{8'hFF, 8'h00, 8'h00, 8'h01};
    int ip0 = in_pops;
    int rp0 = res_pops;
    begin_test();
    push_word(8'hFF, 64'h1111_2222_3333_4444);
    push_word(8'h00, 64'hDEAD_BEEF_0000_0001);
    push_word(8'h00, 64'hDEAD_BEEF_0000_0002);
    push_word(8'h01, 64'hCAFE_0000_0000_00FF);
    push_result(8'b0000_0100, 1'b0);
    wait_res_pops(rp0 + 1);
    checks++; if (out_d.size() != 4) begin errors++; $display("FAIL fwd_word_count: got %0d expected 4", out_d.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (word_at(i) !== exp_d[i] || (i < out_c.size() && out_c[i] !== exp_c[i])) begin
        errors++; $display("FAIL fwd_word%0d: got %h expected %h ctrl %h", i, word_at(i), exp_d[i], exp_c[i]);
      end
    end
    checks++;
    if (wr_cyc.size() < 4 || pop_cyc.size() < 4 || wr_cyc[0] != pop_cyc[0] || wr_cyc[3] != pop_cyc[3]) begin
      errors++; $display("FAIL fwd_latency: write/pop cycle stamps differ (writes %0d pops %0d)", wr_cyc.size(), pop_cyc.size());
    end
    checks++; if (in_pops - ip0 != 4) begin errors++; $display("FAIL fwd_in_pops: got %0d expected 4", in_pops - ip0); end
    checks++; if (res_pops - rp0 != 1) begin errors++; $display("FAIL fwd_res_pops: got %0d expected 1", res_pops - rp0); end
    checks++; if (fwd(2) !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL fwd_count2: got %0d expected %0d", fwd(2), STATS ? 1 : 0); end
  endtask

  task automatic test_drop();
    int ip0 = in_pops;
    int rp0 = res_pops;
    begin_test();
    push_word(8'hFF, 64'h1111_2222_3333_4444);
    push_word(8'h00, 64'hDEAD_BEEF_0000_0001);
    push_word(8'h00, 64'hDEAD_BEEF_0000_0002);
    push_word(8'h01, 64'hCAFE_0000_0000_00FF);
    push_result(8'b0000_0100, 1'b1);
    wait_res_pops(rp0 + 1);
    @(negedge clk);
    checks++; if (out_d.size() != 0) begin errors++; $display("FAIL drop_writes: got %0d expected 0", out_d.size()); end
    checks++; if (in_pops - ip0 != 4) begin errors++; $display("FAIL drop_in_pops: got %0d expected 4", in_pops - ip0); end
    checks++; if (res_pops - rp0 != 1) begin errors++; $display("FAIL drop_res_pops: got %0d expected 1", res_pops - rp0); end
    checks++; if (drop_count !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL drop_count: got %0d expected %0d", drop_count, STATS ? 1 : 0); end
    checks++; if (fwd(2) !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL drop_fwd_unchanged: got %0d expected %0d", fwd(2), STATS ? 1 : 0); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d [5] = '{64'h0001_0000_0000_0010, 64'h11, 64'h12, 64'h13, 64'h14};
    int ip0 = in_pops;
    int rp0 = res_pops;
    int p_hold, w_hold;
    begin_test();
    push_word(8'hFF, 64'h0000_0000_0000_0010);
    push_word(8'h00, 64'h11);
    push_word(8'h00, 64'h12);
    push_word(8'h00, 64'h13);
    push_word(8'h02, 64'h14);
    push_result(8'b0000_0001, 1'b0);
    wait_in_pops(ip0 + 3);
    #1 out_rdy = 1'b0;
    p_hold = in_pops;
    w_hold = out_d.size();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++;
      if (in_fifo_rd_en !== 1'b0 || out_wr !== 1'b0) begin
        errors++; $display("FAIL stall_cycle%0d: got rd_en=%b out_wr=%b expected 0 0", k, in_fifo_rd_en, out_wr);
      end
    end
    checks++;
    if (in_pops != p_hold || out_d.size() != w_hold) begin
      errors++; $display("FAIL stall_hold: pops %0d->%0d writes %0d->%0d", p_hold, in_pops, w_hold, out_d.size());
    end
    out_rdy = 1'b1;
    wait_res_pops(rp0 + 1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (word_at(i) !== exp_d[i]) begin errors++; $display("FAIL stall_word%0d: got %h expected %h", i, word_at(i), exp_d[i]); end
    end
    checks++; if (fwd(0) !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL stall_fwd0: got %0d expected %0d", fwd(0), STATS ? 1 : 0); end
  endtask

  task automatic test_multi_port();
    logic [DW-1:0] exp_d [4] = '{64'hFF81_FFFF_FFFF_FFFF, 64'h00AA_0000_0000_0000, 64'h5, 64'h6};
    int rp0 = res_pops;
    begin_test();
    push_word(8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    push_word(8'h10, 64'h00AA_0000_0000_0000);
    push_word(8'h00, 64'h5);
    push_word(8'h80, 64'h6);
    push_result(8'b1000_0001, 1'b0);
    wait_res_pops(rp0 + 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (word_at(i) !== exp_d[i]) begin errors++; $display("FAIL multi_word%0d: got %h expected %h", i, word_at(i), exp_d[i]); end
    end
    checks++; if (fwd(0) !== (STATS ? 32'd2 : 32'd0)) begin errors++; $display("FAIL multi_fwd0: got %0d expected %0d", fwd(0), STATS ? 2 : 0); end
    checks++; if (fwd(7) !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL multi_fwd7: got %0d expected %0d", fwd(7), STATS ? 1 : 0); end
    checks++; if (fwd(2) !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL multi_fwd2: got %0d expected %0d", fwd(2), STATS ? 1 : 0); end
  endtask

  task automatic test_zero_ports();
    logic [NQ*CNW-1:0] fwd_before = fwd_count;
    logic [CNW-1:0]    drop_before = drop_count;
    int rp0 = res_pops;
    begin_test();
    push_word(8'hFF, 64'h12FF_3456_789A_BCDE);
    push_word(8'h00, 64'h7);
    push_word(8'h04, 64'h8);
    push_result(8'b0000_0000, 1'b0);
    wait_res_pops(rp0 + 1);
    checks++; if (word_at(0) !== 64'h1200_3456_789A_BCDE) begin errors++; $display("FAIL zero_hdr: got %h expected 1200345678 9abcde", word_at(0)); end
    checks++; if (out_d.size() != 3) begin errors++; $display("FAIL zero_word_count: got %0d expected 3", out_d.size()); end
    checks++;
    if (fwd_count !== fwd_before || drop_count !== drop_before) begin
      errors++; $display("FAIL zero_counters: fwd %h drop %0d changed from %h %0d", fwd_count, drop_count, fwd_before, drop_before);
    end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    int n, c0;
    for (int k = 0; k < 2; k++) begin
      v = s_counter; n = 0;
      while (s_counter == v && n < 20) begin @(negedge clk); n++; end
      c0 = cyc; v = s_counter; n = 0;
      while (s_counter == v && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (cyc - c0 != 4 || s_counter !== v + 32'd1) begin
        errors++; $display("FAIL timer_period%0d: got %0d cycles value %0d expected 4 cycles value %0d", k, cyc - c0, s_counter, v + 32'd1);
      end
    end
    @(negedge clk);
    force dut.u_seconds_timer.s_counter = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.u_seconds_timer.s_counter;
    #1;
    checks++; if (s_counter !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_preload: got %h expected ffffffff", s_counter); end
    n = 0;
    while (s_counter == 32'hFFFF_FFFF && n < 20) begin @(negedge clk); n++; end
    checks++; if (s_counter !== 32'd0) begin errors++; $display("FAIL timer_wrap: got %h expected 0", s_counter); end
  endtask

  task automatic test_reset_mid_packet();
    int ip0 = in_pops;
    int rp0 = res_pops;
    begin_test();
    push_word(8'hFF, 64'h0000_0000_0000_0020);
    push_word(8'h00, 64'h21);
    push_word(8'h00, 64'h22);
    push_word(8'h00, 64'h23);
    push_word(8'h01, 64'h24);
    push_result(8'b0000_0001, 1'b0);
    wait_in_pops(ip0 + 2);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_wr !== 1'b0 || out_data !== '0 || out_ctrl !== '0) begin errors++; $display("FAIL midrst_outputs: got wr=%b data=%h ctrl=%h expected 0", out_wr, out_data, out_ctrl); end
    checks++; if (dut.state !== lookup_result_merger_pkg::IDLE) begin errors++; $display("FAIL midrst_state: got %0d expected IDLE", dut.state); end
    checks++; if (in_fifo_rd_en !== 1'b0 || result_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en: got %b%b expected 00", in_fifo_rd_en, result_fifo_rd_en); end
    checks++; if (fwd_count !== '0 || drop_count !== '0 || s_counter !== 32'd0) begin errors++; $display("FAIL midrst_counters: got fwd %h drop %0d s %0d expected 0", fwd_count, drop_count, s_counter); end
    repeat (3) @(negedge clk);
    checks++; if (res_pops != rp0) begin errors++; $display("FAIL midrst_res_pop: got %0d pops expected %0d", res_pops, rp0); end
    in_q.delete(); res_q.delete(); drive_heads();
    reset_n = 1'b1;
    @(negedge clk);
    begin_test();
    push_word(8'hFF, 64'h0000_0000_0000_0030);
    push_word(8'h00, 64'h31);
    push_word(8'h08, 64'h32);
    push_result(8'b0000_0010, 1'b0);
    wait_res_pops(rp0 + 1);
    checks++; if (word_at(0) !== 64'h0002_0000_0000_0030 || out_d.size() != 3) begin errors++; $display("FAIL midrst_recover: got %h (%0d words) expected 0002000000000030 (3 words)", word_at(0), out_d.size()); end
    checks++; if (fwd(1) !== (STATS ? 32'd1 : 32'd0) || fwd(0) !== 32'd0) begin errors++; $display("FAIL midrst_recover_count: got fwd1=%0d fwd0=%0d", fwd(1), fwd(0)); end
  endtask

  initial begin
    reset_n = 1'b0;
    out_rdy = 1'b1;
    drive_heads();
    test_reset();
    test_forward();
    test_drop();
    test_backpressure();
    test_multi_port();
    test_zero_ports();
    test_timer();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lookup_result_merger.md
LOOKUP_RESULT_MERGER -- requirements
Module: lookup_result_merger

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: packet word width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8: control width.
REQ-003 SHALL have parameter NUM_OUTPUT_QUEUES, default 8: one-hot destination port count, at most 16.
REQ-004 SHALL have parameter CNT_WIDTH, default 32: statistics counter width.
REQ-005 SHALL have parameter CLK_PERIOD_NS, default 8: clock period used by the seconds timer.
REQ-006 SHALL have parameter IOQ_CTRL, default 8'hFF: ctrl value marking the IO-queue module header.
REQ-007 SHALL have ports, with clock and reset first: clk in 1 (single clock); reset_n in 1 (asynchronous, active-low).
REQ-008 SHALL have ports in_fifo_data in DATA_WIDTH, in_fifo_ctrl in CTRL_WIDTH, in_fifo_empty in 1, and in_fifo_rd_en out 1 (pop of the packet FIFO).
REQ-009 SHALL have ports result_fifo_empty in 1, result_dst_ports in NUM_OUTPUT_QUEUES, result_drop in 1, and result_fifo_rd_en out 1 (pop of the lookup-result FIFO, whose head is shown).
REQ-010 SHALL have ports out_data out DATA_WIDTH, out_ctrl out CTRL_WIDTH, out_wr out 1, and out_rdy in 1 (downstream can accept a word).
REQ-011 SHALL have ports fwd_count out NUM_OUTPUT_QUEUES*CNT_WIDTH (per-port forwarded packets, port i at [i*CNT_WIDTH +: CNT_WIDTH]), drop_count out CNT_WIDTH, and s_counter out 32 (seconds since reset).

Function
REQ-012 SHALL implement the states IDLE, HDR, PAYLOAD and DROP.
REQ-013 IDLE SHALL go to HDR when both FIFOs are non-empty and result_drop=0, or to DROP when both are non-empty and result_drop=1.
REQ-014 A word SHALL transfer when the state is not IDLE, in_fifo_empty=0 and either out_rdy=1 or the state is DROP; in_fifo_rd_en SHALL equal this transfer condition.
REQ-015 In HDR, a transferred word with ctrl==IOQ_CTRL SHALL have bits [48 +: NUM_OUTPUT_QUEUES] replaced by result_dst_ports; other bits and other header words SHALL pass unchanged.
REQ-016 HDR SHALL go to PAYLOAD on the first transferred word with ctrl==0.
REQ-017 PAYLOAD SHALL go to IDLE on a transferred word with ctrl!=0 (the EOP word).
REQ-018 DROP SHALL consume words without writing and SHALL track the header/payload phase identically to HDR/PAYLOAD, returning to IDLE on the EOP word.
REQ-019 result_fifo_rd_en SHALL pulse for exactly one cycle, coincident with the EOP transfer.
REQ-020 out_data, out_ctrl and out_wr SHALL be registered with 1-cycle latency from the transfer; out_wr SHALL be 0 in IDLE and DROP.
REQ-021 On EOP of a forwarded packet, fwd_count[i] SHALL increment for every set bit i of result_dst_ports.
REQ-022 On EOP of a dropped packet, drop_count SHALL increment; all counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-023 A forwarded packet with result_dst_ports==0 SHALL be forwarded with an all-zero port field and SHALL increment no counter.
REQ-024 The seconds timer SHALL use ns_cnt counting 0..(1_000_000_000/CLK_PERIOD_NS - 1); at the terminal value ns_cnt SHALL go to 0 and s_counter SHALL increment, wrapping 2^32-1 to 0.
REQ-025 When out_rdy=0 in HDR/PAYLOAD, state and FIFOs SHALL hold and out_wr SHALL be 0 the next cycle.

Reset
REQ-026 Asserting reset_n low SHALL asynchronously force IDLE, out_data=0, out_ctrl=0, out_wr=0, all counters=0, ns_cnt=0 and s_counter=0.
REQ-027 in_fifo_rd_en and result_fifo_rd_en SHALL be 0 during reset; a reset mid-packet SHALL abandon the packet without popping the result, and after release parsing SHALL restart at the next FIFO word.

Configuration
REQ-028 With LOOKUP_MERGER_STATS_EN defined, fwd_count and drop_count SHALL count as specified.
REQ-029 Without LOOKUP_MERGER_STATS_EN, fwd_count and drop_count SHALL be constant 0 and no counter registers SHALL be synthesised; the datapath and timer SHALL be unchanged.

Structure
REQ-030 The shared package SHALL hold the state encoding, the IOQ dst-port bit offset (48) and the default IOQ_CTRL constant.
REQ-031 The seconds timer SHALL be a sub-module named seconds_timer, parametrised by CLK_PERIOD_NS.

Verification
REQ-032 The bench SHALL check: 4-word packet (IOQ header, 2 data words, EOP ctrl=0x01), result ports=8'b0000_0100, drop=0 -> 4 out words 1 cycle later, header bits[55:48]=0x04, fwd_count[2]=1, one result pop.
REQ-033 The bench SHALL check: same packet with drop=1 -> out_wr never asserted, 4 input pops, drop_count=1, one result pop.
REQ-034 The bench SHALL check: out_rdy low for 3 cycles mid-payload -> no pops and no writes for those cycles, and data is intact afterwards.
REQ-035 The bench SHALL check: ports=8'b1000_0001 -> fwd_count[0] and fwd_count[7] each +1.
REQ-036 The bench SHALL check: CLK_PERIOD_NS=250_000_000 -> s_counter increments every 4 cycles; preloaded at 32'hFFFF_FFFF it wraps to 0.
REQ-037 The bench SHALL check: reset_n pulsed low during PAYLOAD -> outputs zero immediately, state IDLE, result FIFO not popped.
